// File: rtl/c5_uart_tx.sv
// c5_uart_tx: Wishbone-attached 8N1 UART transmitter with a byte FIFO.
//
// Ports
//   I_clk      sole clock, rising edge
//   I_rst      synchronous active-high reset
//   I_cyc      Wishbone bus cycle
//   I_stb      Wishbone strobe / chip select
//   I_we       1 = write, 0 = read
//   I_adr      0 = DATA, 1 = STATUS
//   I_dat      write data, bits [7:0] used
//   O_dat      read data, zero unless O_ack is high
//   O_ack      one-cycle registered acknowledge
//   O_stall    DATA write refused this cycle because the FIFO is full
//   O_uart_tx  serial output, idles high
//   O_busy     frame in progress or bytes queued
//
// Transmitter states
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (low) for CLK_DIV cycles
//   S_DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   S_STOP  | stop bit (high); may chain straight into the next start bit

module c5_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_cyc,
    input  logic        I_stb,
    input  logic        I_we,
    input  logic        I_adr,
    input  logic [31:0] I_dat,
    output logic [31:0] O_dat,
    output logic        O_ack,
    output logic        O_stall,
    output logic        O_uart_tx,
    output logic        O_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full;
    logic          accept, push, pop, baud_last;
    logic [7:0]    head_byte;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic [31:0]   status;
    logic          unused_dat;

    assign unused_dat = ^I_dat[31:8];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign O_stall = I_cyc & I_stb & I_we & ~I_adr & fifo_full;
    assign accept  = I_cyc & I_stb & ~O_stall;
    assign push    = accept & I_we & ~I_adr;

    assign baud_last = (cnt_q == CNT_LAST);
    // Pop from IDLE, or on the final stop-bit cycle to chain frames without a gap.
    assign pop = ~fifo_empty &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last));
    assign head_byte = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q[AW-1:0]] <= I_dat[7:0];
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head_byte;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            // tx_q takes the bit that becomes shift_q[0] after this shift.
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= head_byte;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign O_busy = (state_q != S_IDLE) | ~fifo_empty;
    assign status = {29'd0, O_busy, fifo_full, fifo_empty};

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept & ~I_we & I_adr) ? status : 32'd0;
        end
    end

    assign O_ack     = ack_q;
    assign O_dat     = dat_q;
    assign O_uart_tx = tx_q;

endmodule

// File: tb/tb_c5_uart_tx.sv
module tb_c5_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
    logic [31:0] dat_w = 32'd0;
    logic [31:0] dat_r;
    logic        ack, stall, tx, busy;

    c5_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .I_clk(clk), .I_rst(rst), .I_cyc(cyc), .I_stb(stb), .I_we(we),
        .I_adr(adr), .I_dat(dat_w), .O_dat(dat_r), .O_ack(ack),
        .O_stall(stall), .O_uart_tx(tx), .O_busy(busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { logic [7:0] b; int start; } frame_t;
    typedef struct { bit chk; logic [31:0] dat; } ack_t;
    frame_t exp_frames[$];
    ack_t   exp_acks[$];

    int last_end   = 0;   // model: edge at which the last predicted frame ends
    int last_acc   = 0;   // edge at which the most recent access was accepted
    int last_stall = 0;   // stalled cycles seen by the most recent access

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic bus(input bit w, input bit a, input logic [31:0] d,
                       input bit chk, input logic [31:0] expv);
        int n;
        int st;
        n = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 500) begin
                fail_now("bus_stall_timeout");
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                sync();
                return;
            end
        end
        @(posedge clk);
        #1;
        last_acc   = edge_n;
        last_stall = n;
        exp_acks.push_back('{chk: (w ? 1'b1 : chk), dat: (w ? 32'd0 : expv)});
        if (w && !a) begin
            // Frame starts the edge after acceptance, or as soon as the previous one ends.
            st = (last_acc + 1 > last_end) ? last_acc + 1 : last_end;
            last_end = st + FRAME;
            exp_frames.push_back('{b: d[7:0], start: st});
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0;
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        t = -1;
        forever begin
            @(negedge clk);
            if (!busy) begin
                t = edge_n;
                break;
            end
            n++;
            if (n > 3000) begin
                fail_now("wait_idle_timeout");
                break;
            end
        end
        sync();
    endtask

    task automatic poll_not_full();
        logic [31:0] r;
        int n;
        n = 0;
        forever begin
            bus(1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
            @(negedge clk);
            r = dat_r;
            sync();
            if (!r[1]) break;
            n++;
            if (n > 500) begin
                fail_now("poll_full_timeout");
                break;
            end
        end
    endtask

    // Serial monitor: every low seen on an idle line must be the start of the
    // next expected frame {stop=1, byte, start=0}, each bit held DIV cycles.
    initial begin : rx_mon
        frame_t     f;
        logic [9:0] fr;
        logic [7:0] rx;
        int         nbad;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) continue;
            if (exp_frames.size() == 0) begin
                fail_now("unexpected_frame");
                repeat (FRAME - 1) @(negedge clk);
                continue;
            end
            f = exp_frames.pop_front();
            check("frame_start_edge", edge_n, f.start);
            fr    = {1'b1, f.b, 1'b0};
            rx    = 8'd0;
            nbad  = 0;
            abort = 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) @(negedge clk);
                if (rst) begin
                    abort = 1'b1;
                    break;
                end
                if (tx !== fr[k / DIV]) nbad++;
                if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2)
                    rx[k / DIV - 1] = tx;
            end
            if (!abort) begin
                check("rx_byte", {24'd0, rx}, {24'd0, f.b});
                check("frame_shape_errors", nbad, 0);
            end
        end
    end

    // Ack monitor: one ack per accepted access, data only while acked.
    ack_t a_exp;
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                if (exp_acks.size() == 0) fail_now("unexpected_ack");
                else begin
                    a_exp = exp_acks.pop_front();
                    if (a_exp.chk) check("ack_rdata", dat_r, a_exp.dat);
                end
            end else begin
                check("dat_zero_without_ack", dat_r, 32'd0);
            end
        end
    end

    initial begin : stim
        int t;
        int s0;
        int acc5;
        rst = 1'b1;
        repeat (5) sync();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        sync();
        bus(1'b0, 1'b1, 32'd0, 1'b1, 32'h1);

        // single byte
        bus(1'b1, 1'b0, 32'hA5, 1'b0, 32'd0);
        s0 = last_acc + 1;
        wait_idle(t);
        check("single_busy_drop", t, s0 + FRAME);

        // back-to-back
        bus(1'b1, 1'b0, 32'h41, 1'b0, 32'd0);
        s0 = last_acc + 1;
        bus(1'b1, 1'b0, 32'h42, 1'b0, 32'd0);
        bus(1'b1, 1'b0, 32'h43, 1'b0, 32'd0);
        wait_idle(t);
        check("b2b_span", t - s0, 3 * FRAME);

        // status / data read / status write while two bytes are queued
        bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        bus(1'b0, 1'b1, 32'd0, 1'b1, 32'h4);
        bus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0);
        bus(1'b1, 1'b1, 32'hFF, 1'b0, 32'd0);
        wait_idle(t);

        // fill and stall
        bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        s0 = last_acc + 1;
        for (int i = 0; i < 4; i++) bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        acc5 = last_acc;
        bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        check("stall_accept_edge", last_acc, s0 + FRAME + 1);
        check("stall_cycles", last_stall, s0 + FRAME - acc5);
        wait_idle(t);

        // reset mid-frame
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, {24'd0, 8'($urandom)}, 1'b0, 32'd0);
        repeat (15) sync();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sync();
            check("rst_mid_tx", {31'd0, tx}, 32'd1);
            check("rst_mid_ack", {31'd0, ack}, 32'd0);
            check("rst_mid_busy", {31'd0, busy}, 32'd0);
        end
        exp_frames.delete();
        last_end = 0;
        rst = 1'b0;
        sync();
        bus(1'b0, 1'b1, 32'd0, 1'b1, 32'h1);
        repeat (2 * FRAME) sync();

        // pointer wrap with polling on the full bit
        for (int i = 0; i < 10; i++) begin
            poll_not_full();
            bus(1'b1, 1'b0, i, 1'b0, 32'd0);
        end
        wait_idle(t);
        bus(1'b0, 1'b1, 32'd0, 1'b1, 32'h1);

        // randomised traffic with occasional DATA reads
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 60)) sync();
            if ($urandom_range(0, 4) == 0) bus(1'b0, 1'b0, $urandom, 1'b1, 32'd0);
            else bus(1'b1, 1'b0, $urandom, 1'b0, 32'd0);
        end
        wait_idle(t);
        check("random_busy_drop", t, last_end);
        bus(1'b0, 1'b1, 32'd0, 1'b1, 32'h1);

        repeat (5) sync();
        check("acks_drained", exp_acks.size(), 0);
        check("frames_drained", exp_frames.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
